dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//   Shares the single-port data RAM (ram_1port) between two requesters: port 0 = core data port
//   (core_top data_memory_*), port 1 = secondary master (program loader / debug / DMA).
//   Combinational per-cycle grant, round-robin on conflict, optional locked bursts with a fairness cap.
//   Routes the 1-cycle-latency read data back to the granted requester with a registered valid.
// PARAMETERS
//   ADDR_W     32  address width, all ports
//   DATA_W     32  data width, all ports
//   MAX_BURST  8   max consecutive locked grants to one owner while the other is waiting (>=1)
// PORTS
//   clk        in   1       system clock, all logic on rising edge
//   reset      in   1       synchronous, active-low (reset==0 resets on the next rising edge)
//   mN_req     in   1       N=0,1: access request; addr/we/wd valid while high
//   mN_we      in   1       1 = write, 0 = read
//   mN_lock    in   1       hold ownership after this grant (burst)
//   mN_addr    in   ADDR_W  byte address
//   mN_wd      in   DATA_W  write data
//   mN_gnt     out  1       access accepted this cycle (comb.); transfer = req & gnt
//   mN_rvalid  out  1       registered: read data for this port valid on mN_rd
//   mN_rd      out  DATA_W  read data (= mem_rd, qualified by mN_rvalid)
//   mem_we     out  1       RAM write enable
//   mem_addr   out  ADDR_W  RAM address
//   mem_wd     out  DATA_W  RAM write data
//   mem_rd     in   DATA_W  RAM read data, valid one cycle after address presented
// BEHAVIOUR
//   - State: IDLE, OWN0, OWN1; regs last (last granted port), burst_cnt (0..MAX_BURST), rvalid0/1.
//   - Reset (reset==0 at edge): state=IDLE, last=1 (port 0 wins first tie), burst_cnt=0, rvalid=0.
//     While reset==0: m0_gnt=m1_gnt=0, mem_we=0. Reset mid-burst drops ownership; in-flight rvalid lost.
//   - IDLE grant: single req -> grant it; both -> grant port != last; none -> no grant.
//   - OWNx grant: only port x may be granted (if mx_req); other port held off (gnt=0) even if x idle.
//   - No grant: mem_we=0, mem_addr=0, mem_wd=0. Grant to x: mem_* = mx_* with mem_we = mx_we.
//   - At most one gnt high per cycle; a port's gnt is never high without its req.
//   - Transitions (evaluated on transfer to x, last<=x):
//       IDLE -> OWNx if mx_lock=1, burst_cnt<=1; else stay IDLE.
//       OWNx -> OWNx if mx_lock=1 and not capped, burst_cnt++ (saturates at MAX_BURST).
//       OWNx -> IDLE if mx_lock=0 on the transfer, burst_cnt<=0.
//     Also OWNx -> IDLE in any cycle where mx_lock=0 and mx_req=0 (owner released without access).
//     Cap: in OWNx, if burst_cnt==MAX_BURST and other port req=1 -> no grant to x this cycle, go IDLE;
//     since last==x, the other port wins the next cycle. Cap ignored while the other port is idle.
//   - Read return: mN_rvalid <= mN_req & mN_gnt & ~mN_we (1 cycle latency); writes produce no rvalid.
//     mN_rd driven = mem_rd continuously. Back-to-back reads give rvalid every cycle.
//   - Throughput: one transfer per cycle, no bubbles on grant handoff outside the cap event.
//   - Address/data are not checked or aligned; passed through unchanged.
// TESTING
//   1 Reset: hold reset=0 4 cycles with m0_req=m1_req=1 -> both gnt=0, mem_we=0; after release
//     first grant goes to m0.
//   2 Single read: m0 read addr 0x10 with RAM[0x10]=0xDEADBEEF -> m0_gnt same cycle, next cycle
//     m0_rvalid=1, m0_rd=0xDEADBEEF, m1_rvalid=0.
//   3 Contention: both req continuously (no lock) -> grants alternate 0,1,0,1...; 10 cycles give
//     exactly 5 each.
//   4 Locked burst: m1 lock+req writes 0x100..0x11C (8 words) while m0 req idle -> 8 consecutive m1
//     grants, RAM holds data; m1_lock=0 on last -> IDLE.
//   5 Fairness cap: MAX_BURST=8, m1 locked req forever, m0 req from cycle 2 -> m1 gets 8 grants,
//     then 1 no-grant cycle, then m0 granted.
//   6 Reset mid-burst: reset=0 during OWN1 with read in flight -> next cycle m1_rvalid=0, state IDLE,
//     tie after release goes to m0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data RAM between the core data port (m0)
// and a secondary master (m1). Grants are combinational and issued every cycle.
// Ties go round-robin. A master may lock ownership for a burst, and a fairness
// cap limits how long it keeps the RAM while the other master waits. Read data
// comes back one cycle later, tagged with a registered per-port valid.
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wd,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rd,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wd,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rd,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  localparam int               CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             last_q, last_d;        // port granted most recently
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             m0_rvalid_q, m0_rvalid_d;
  logic             m1_rvalid_q, m1_rvalid_d;

  logic at_cap;
  logic xfer, xfer_sel, xfer_lock;
  logic own_sel, own_req, own_lock, other_req;

  assign at_cap = (burst_cnt_q == CNT_MAX);

  // Grant decision. The reset input gates the grants directly, so nothing reaches the RAM while reset is held.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first; a path that skips an assignment would infer a latch.
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (reset) begin
      case (state_q)
        IDLE: begin
          if (m0_req && m1_req) begin
            m0_gnt = last_q;
            m1_gnt = ~last_q;
          end else begin
            m0_gnt = m0_req;
            m1_gnt = m1_req;
          end
        end
        OWN0:    m0_gnt = m0_req && !(at_cap && m1_req);
        OWN1:    m1_gnt = m1_req && !(at_cap && m0_req);
        default: ;
      endcase
    end
  end

  // RAM port mux: pass the granted master's request through unchanged, and drive zeros when nothing is granted.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_wd   = '0;
    if (m1_gnt) begin
      mem_we   = m1_we;
      mem_addr = m1_addr;
      mem_wd   = m1_wd;
    end else if (m0_gnt) begin
      mem_we   = m0_we;
      mem_addr = m0_addr;
      mem_wd   = m0_wd;
    end
  end

  // Next-state logic: ownership, round-robin pointer, burst counter and read-valid tags.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    burst_cnt_d = burst_cnt_q;

    xfer      = m0_gnt | m1_gnt;
    xfer_sel  = m1_gnt;
    xfer_lock = m1_gnt ? m1_lock : m0_lock;
    own_sel   = (state_q == OWN1);
    own_req   = own_sel ? m1_req  : m0_req;
    own_lock  = own_sel ? m1_lock : m0_lock;
    other_req = own_sel ? m0_req  : m1_req;

    if (xfer) last_d = xfer_sel;

    case (state_q)
      IDLE: begin
        if (xfer && xfer_lock) begin
          state_d     = xfer_sel ? OWN1 : OWN0;
          burst_cnt_d = CNT_W'(1);
        end
      end
      OWN0, OWN1: begin
        if (xfer) begin
          if (!xfer_lock) begin
            state_d     = IDLE;
            burst_cnt_d = '0;
          end else if (!at_cap) begin
            burst_cnt_d = burst_cnt_q + 1'b1;
          end
        end else if ((at_cap && other_req) || (!own_req && !own_lock)) begin
          // The owner is either capped by a waiting master or has let go without an access.
          state_d     = IDLE;
          burst_cnt_d = '0;
        end
      end
      default: begin
        state_d     = IDLE;
        burst_cnt_d = '0;
      end
    endcase

    m0_rvalid_d = m0_gnt & ~m0_we;
    m1_rvalid_d = m1_gnt & ~m1_we;
  end

  // State registers with synchronous active-low reset. Port 0 wins the first tie after reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so that every flop samples values from before the edge.
    if (!reset) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      burst_cnt_q <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
    end
  end

  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rd     = mem_rd;
  assign m1_rd     = mem_rd;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table-driven cycle vectors with a read-data scoreboard.
// A behavioural 1-cycle RAM sits on the mem_* port. A shadow copy of the RAM,
// kept by the bench, predicts what each read should return.
module tb_dmem_arbiter;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int MAX_BURST = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              m0_req, m0_we, m0_lock, m0_gnt, m0_rvalid;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wd, m0_rd;
  logic              m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wd, m1_rd;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wd, mem_rd;

  dmem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wd(m0_wd),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rd(m0_rd),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wd(m1_wd),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rd(m1_rd),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // Initial RAM image. Word 4 (byte address 0x10) holds 0xDEADBEEF.
  function automatic logic [31:0] preload(input int i);
    return (i == 4) ? 32'hDEAD_BEEF : (32'hA500_0000 | 32'(i));
  endfunction

  // Behavioural single-port RAM with 1-cycle read latency. Unwritten words return the preload image.
  logic [31:0] ram_data [256];
  bit          ram_written [256];
  always @(posedge clk) begin
    if (mem_we) begin
      ram_data[mem_addr[9:2]]    <= mem_wd;
      ram_written[mem_addr[9:2]] <= 1'b1;
    end
    mem_rd <= ram_written[mem_addr[9:2]] ? ram_data[mem_addr[9:2]] : preload(int'(mem_addr[9:2]));
  end

  typedef struct {
    string       name;
    logic        rst_n;
    logic        r0, w0, l0;
    logic [31:0] a0, d0;
    logic        r1, w1, l1;
    logic [31:0] a1, d1;
    logic        g0, g1;
  } vec_t;

  function automatic vec_t mk(input string name, input logic rst_n,
                              input logic r0, w0, l0, input logic [31:0] a0, d0,
                              input logic r1, w1, l1, input logic [31:0] a1, d1,
                              input logic g0, g1);
    vec_t v;
    v.name = name; v.rst_n = rst_n;
    v.r0 = r0; v.w0 = w0; v.l0 = l0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.l1 = l1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1;
    return v;
  endfunction

  int          n_tests = 0;
  int          n_fail  = 0;
  int          gcnt0, gcnt1;
  logic [31:0] shadow [256];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  vec_t        vecs [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check(name, {31'b0, act}, {31'b0, exp});
  endtask

  // One cycle: drive at the falling edge, check the combinational outputs, then check the registered outputs after the rising edge.
  task automatic step(input vec_t v);
    logic        e_we, rv0, rv1;
    logic [31:0] e_addr, e_wd;
    reset   = v.rst_n;
    m0_req  = v.r0; m0_we = v.w0; m0_lock = v.l0; m0_addr = v.a0; m0_wd = v.d0;
    m1_req  = v.r1; m1_we = v.w1; m1_lock = v.l1; m1_addr = v.a1; m1_wd = v.d1;
    #1;
    check1({v.name, " m0_gnt"}, m0_gnt, v.g0);
    check1({v.name, " m1_gnt"}, m1_gnt, v.g1);
    e_we   = (v.g0 & v.w0) | (v.g1 & v.w1);
    e_addr = v.g1 ? v.a1 : (v.g0 ? v.a0 : 32'h0);
    e_wd   = v.g1 ? v.d1 : (v.g0 ? v.d0 : 32'h0);
    check1({v.name, " mem_we"}, mem_we, e_we);
    check({v.name, " mem_addr"}, mem_addr, e_addr);
    check({v.name, " mem_wd"}, mem_wd, e_wd);
    if (m0_gnt) gcnt0++;
    if (m1_gnt) gcnt1++;
    rv0 = v.g0 & ~v.w0;
    rv1 = v.g1 & ~v.w1;
    if (rv0) q0.push_back(shadow[v.a0[9:2]]);
    if (rv1) q1.push_back(shadow[v.a1[9:2]]);
    if (v.g0 & v.w0) shadow[v.a0[9:2]] = v.d0;
    if (v.g1 & v.w1) shadow[v.a1[9:2]] = v.d1;
    @(posedge clk);
    #1;
    check1({v.name, " m0_rvalid"}, m0_rvalid, rv0);
    check1({v.name, " m1_rvalid"}, m1_rvalid, rv1);
    if (rv0 && q0.size() > 0) check({v.name, " m0_rd"}, m0_rd, q0.pop_front());
    if (rv1 && q1.size() > 0) check({v.name, " m1_rd"}, m1_rd, q1.pop_front());
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) shadow[i] = preload(i);

    // Table: reset with both masters requesting, the first tie, a single read, then 10 cycles of contention.
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk("reset", 1'b0, 1,1,0, 32'h20, 32'h1111_1111, 1,1,1, 32'h24, 32'h2222_2222, 0,0));
    vecs.push_back(mk("first_tie",   1'b1, 1,0,0, 32'h10, 0, 1,0,0, 32'h14, 0, 1,0));
    vecs.push_back(mk("single_read", 1'b1, 1,0,0, 32'h10, 0, 0,0,0, 32'h0,  0, 1,0));
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk("contend", 1'b1,
                        1,1,0, 32'h40 + 32'(4*i), 32'hC0DE_0000 + 32'(i),
                        1,0,0, 32'h3C + 32'(4*i), 32'h0,
                        (i % 2) == 1, (i % 2) == 0));
    gcnt0 = 0; gcnt1 = 0;
    foreach (vecs[i]) begin
      if (i == 6) begin gcnt0 = 0; gcnt1 = 0; end
      step(vecs[i]);
    end
    check("contend m0 grants", 32'(gcnt0), 32'd5);
    check("contend m1 grants", 32'(gcnt1), 32'd5);

    // Locked m1 write burst of 8 words. The owner pauses once mid-burst, and m0 stays held off during the pause.
    for (int k = 0; k < 4; k++)
      step(mk("burst_wr", 1'b1, 0,0,0, 0, 0, 1,1,1, 32'h100 + 32'(4*k), 32'hB000_0000 + 32'(k), 0,1));
    step(mk("own_hold", 1'b1, 1,0,0, 32'h10, 0, 0,0,1, 0, 0, 0,0));
    for (int k = 4; k < 8; k++)
      step(mk("burst_wr", 1'b1, 0,0,0, 0, 0, 1,1,(k != 7), 32'h100 + 32'(4*k), 32'hB000_0000 + 32'(k), 0,1));
    step(mk("burst_rd0",    1'b1, 1,0,0, 32'h100, 0, 0,0,0, 0,       0, 1,0));
    step(mk("burst_rd_tie", 1'b1, 1,0,0, 32'h11C, 0, 1,0,0, 32'h104, 0, 0,1));
    step(mk("burst_rd1",    1'b1, 1,0,0, 32'h11C, 0, 0,0,0, 0,       0, 1,0));

    // The owner releases without an access. m1 is held off for that cycle and granted on the next.
    step(mk("own0_start",    1'b1, 1,0,1, 32'h10, 0, 0,0,0, 0,      0, 1,0));
    step(mk("own0_release",  1'b1, 0,0,0, 0,      0, 1,0,0, 32'h14, 0, 0,0));
    step(mk("after_release", 1'b1, 0,0,0, 0,      0, 1,0,0, 32'h14, 0, 0,1));

    // m0 holds a locked run of 10 reads while m1 is idle, so the cap is ignored. m1 then arrives and the cap fires.
    for (int k = 0; k < 10; k++)
      step(mk("sat_run", 1'b1, 1,0,1, 32'h40 + 32'(4*k), 0, 0,0,0, 0, 0, 1,0));
    step(mk("cap0",         1'b1, 1,0,1, 32'h80, 0, 1,0,0, 32'h14, 0, 0,0));
    step(mk("cap0_handoff", 1'b1, 1,0,1, 32'h80, 0, 1,0,0, 32'h14, 0, 0,1));

    // Fairness cap: m1 is locked indefinitely and m0 requests from cycle 2 onward.
    for (int c = 0; c < 12; c++) begin
      logic g0, g1;
      g0 = (c == 9);
      g1 = (c < 8) || (c >= 10);
      step(mk("fair_cap", 1'b1, (c >= 2) && (c != 11), 0, 0, 32'h10, 0,
              1, 0, 1, 32'h200 + 32'(4*c), 0, g0, g1));
    end

    // Reset while m1 owns the RAM: no grant and no read valid. The tie after release goes to m0.
    step(mk("rst_mid",  1'b0, 0,0,0, 0,      0, 1,0,1, 32'h240, 0, 0,0));
    step(mk("rst_tie",  1'b1, 1,0,0, 32'h10, 0, 1,0,0, 32'h14,  0, 1,0));
    step(mk("rst_tie2", 1'b1, 1,0,0, 32'h10, 0, 1,0,0, 32'h14,  0, 0,1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
